axi_mem_tester: RTL and testbench

AXI_MEM_TESTER -- requirements
Module: axi_mem_tester

---
 rtl/axi_mem_tester.sv | 220 ++++++++++++++++++++++
 tb/tb_axi_mem_tester.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_tester.sv
// AXI4 DDR memory tester: writes num_bursts INCR bursts of a seeded address pattern,
// reads them back, and reports the error count and the first failing address.
module axi_mem_tester #(
    parameter int DW          = 128,
    parameter int AW          = 32,
    parameter int BURST_BEATS = 16
) (
    input  logic            mig_clk,
    input  logic            mig_rst,
    input  logic            init_calib_complete,
    input  logic            start,
    input  logic [31:0]     seed,
    input  logic [AW-1:0]   base_addr,
    input  logic [15:0]     num_bursts,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [15:0]     err_count,
    output logic [AW-1:0]   first_err_addr,
    output logic [AW-1:0]   m_axi_awaddr,
    output logic [7:0]      m_axi_awlen,
    output logic [2:0]      m_axi_awsize,
    output logic [1:0]      m_axi_awburst,
    output logic            m_axi_awvalid,
    input  logic            m_axi_awready,
    output logic [DW-1:0]   m_axi_wdata,
    output logic [DW/8-1:0] m_axi_wstrb,
    output logic            m_axi_wlast,
    output logic            m_axi_wvalid,
    input  logic            m_axi_wready,
    input  logic [1:0]      m_axi_bresp,
    input  logic            m_axi_bvalid,
    output logic            m_axi_bready,
    output logic [AW-1:0]   m_axi_araddr,
    output logic [7:0]      m_axi_arlen,
    output logic [2:0]      m_axi_arsize,
    output logic [1:0]      m_axi_arburst,
    output logic            m_axi_arvalid,
    input  logic            m_axi_arready,
    input  logic [DW-1:0]   m_axi_rdata,
    input  logic [1:0]      m_axi_rresp,
    input  logic            m_axi_rlast,
    input  logic            m_axi_rvalid,
    output logic            m_axi_rready
);

    localparam int BEAT_W = $clog2(BURST_BEATS);
    localparam logic [AW-1:0] BEAT_BYTES  = AW'(16);
    localparam logic [AW-1:0] BURST_BYTES = AW'(BURST_BEATS * 16);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        WR_RESP = 3'd3,
        RD_ADDR = 3'd4,
        RD_DATA = 3'd5,
        DONE    = 3'd6
    } state_t;

    function automatic logic [DW-1:0] beat_pattern(input logic [AW-1:0] addr, input logic [31:0] s);
        logic [31:0] a32;
        a32 = 32'(addr);
        return {4{a32 ^ s}};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t              state_q, state_d;
    logic                awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, busy_q, done_q;
    logic                awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d, busy_d, done_d;
    logic [15:0]         err_count_q;
    logic [AW-1:0]       first_err_addr_q;
    logic [31:0]         seed_q;
    logic [AW-1:0]       base_q, burst_addr_q, beat_addr_q;
    logic [15:0]         nb_q, burst_cnt_q;
    logic [BEAT_W-1:0]   beat_cnt_q;
    logic                start_ok, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                last_beat, last_burst, rd_bad, err_hit;
    logic [AW-1:0]       err_addr;

    assign start_ok   = start && init_calib_complete && (state_q == IDLE || state_q == DONE);
    assign aw_hs      = awvalid_q && m_axi_awready;
    assign w_hs       = wvalid_q && m_axi_wready;
    assign b_hs       = bready_q && m_axi_bvalid;
    assign ar_hs      = arvalid_q && m_axi_arready;
    assign r_hs       = rready_q && m_axi_rvalid;
    assign last_beat  = (beat_cnt_q == BEAT_W'(BURST_BEATS - 1));
    assign last_burst = (burst_cnt_q == nb_q - 16'd1);

    // State register; every valid/ready is a flop loaded from the next state.
    always_ff @(posedge mig_clk or posedge mig_rst) begin
        if (mig_rst) begin
            state_q          <= IDLE;
            awvalid_q        <= 1'b0;
            wvalid_q         <= 1'b0;
            bready_q         <= 1'b0;
            arvalid_q        <= 1'b0;
            rready_q         <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            err_count_q      <= 16'd0;
            first_err_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            if (start_ok) begin
                err_count_q      <= 16'd0;
                first_err_addr_q <= '0;
            end else if (err_hit) begin
                err_count_q <= sat_inc(err_count_q);
                if (err_count_q == 16'd0)
                    first_err_addr_q <= err_addr;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start_ok) state_d = (num_bursts == 16'd0) ? DONE : WR_ADDR;
            WR_ADDR:    if (aw_hs) state_d = WR_DATA;
            WR_DATA:    if (w_hs && last_beat) state_d = WR_RESP;
            WR_RESP:    if (b_hs) state_d = last_burst ? RD_ADDR : WR_ADDR;
            RD_ADDR:    if (ar_hs) state_d = RD_DATA;
            RD_DATA:    if (r_hs && last_beat) state_d = last_burst ? DONE : RD_ADDR;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        awvalid_d = (state_d == WR_ADDR);
        wvalid_d  = (state_d == WR_DATA);
        bready_d  = (state_d == WR_RESP);
        arvalid_d = (state_d == RD_ADDR);
        rready_d  = (state_d == RD_DATA);
        busy_d    = !(state_d == IDLE || state_d == DONE);
        done_d    = (state_d == DONE);
    end

    // Data mismatch, bad rresp and misplaced rlast on one beat collapse into one error.
    always_comb begin
        rd_bad   = (m_axi_rdata != beat_pattern(beat_addr_q, seed_q)) ||
                   (m_axi_rresp != 2'b00) || (m_axi_rlast != last_beat);
        err_hit  = 1'b0;
        err_addr = beat_addr_q;
        if (b_hs && m_axi_bresp != 2'b00) begin
            err_hit  = 1'b1;
            err_addr = burst_addr_q;
        end
        if (r_hs && rd_bad) begin
            err_hit  = 1'b1;
            err_addr = beat_addr_q;
        end
    end

    // Run context is loaded on every accepted start, so it needs no reset.
    always_ff @(posedge mig_clk) begin
        if (start_ok) begin
            seed_q       <= seed;
            nb_q         <= num_bursts;
            base_q       <= base_addr & ~AW'(8'hFF);
            burst_addr_q <= base_addr & ~AW'(8'hFF);
            beat_addr_q  <= base_addr & ~AW'(8'hFF);
            burst_cnt_q  <= 16'd0;
            beat_cnt_q   <= '0;
        end else begin
            if (w_hs || r_hs) begin
                beat_addr_q <= beat_addr_q + BEAT_BYTES;
                beat_cnt_q  <= last_beat ? '0 : beat_cnt_q + 1'b1;
            end
            if (b_hs) begin
                if (last_burst) begin
                    burst_addr_q <= base_q;
                    beat_addr_q  <= base_q;
                    burst_cnt_q  <= 16'd0;
                end else begin
                    burst_addr_q <= burst_addr_q + BURST_BYTES;
                    burst_cnt_q  <= burst_cnt_q + 16'd1;
                end
            end
            if (r_hs && last_beat) begin
                burst_addr_q <= burst_addr_q + BURST_BYTES;
                burst_cnt_q  <= burst_cnt_q + 16'd1;
            end
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = done_q && (err_count_q == 16'd0);
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;

    assign m_axi_awaddr   = burst_addr_q;
    assign m_axi_awlen    = 8'(BURST_BEATS - 1);
    assign m_axi_awsize   = 3'b100;
    assign m_axi_awburst  = 2'b01;
    assign m_axi_awvalid  = awvalid_q;
    assign m_axi_wdata    = beat_pattern(beat_addr_q, seed_q);
    assign m_axi_wstrb    = '1;
    assign m_axi_wlast    = last_beat;
    assign m_axi_wvalid   = wvalid_q;
    assign m_axi_bready   = bready_q;
    assign m_axi_araddr   = burst_addr_q;
    assign m_axi_arlen    = 8'(BURST_BEATS - 1);
    assign m_axi_arsize   = 3'b100;
    assign m_axi_arburst  = 2'b01;
    assign m_axi_arvalid  = arvalid_q;
    assign m_axi_rready   = rready_q;

endmodule

// File: tb/tb_axi_mem_tester.sv
// Bench for axi_mem_tester: AXI slave responder with a small memory, optional ready
// stalls and fault injection, driven by a table of runs plus reset/start corner cases.
`timescale 1ns/1ps
module tb_axi_mem_tester;

    localparam int DW = 128;
    localparam int AW = 32;
    localparam int BB = 16;

    logic            mig_clk = 1'b0;
    logic            mig_rst = 1'b0;
    logic            init_calib_complete = 1'b1;
    logic            start = 1'b0;
    logic [31:0]     seed = '0;
    logic [AW-1:0]   base_addr = '0;
    logic [15:0]     num_bursts = '0;
    logic            busy, done, pass;
    logic [15:0]     err_count;
    logic [AW-1:0]   first_err_addr;
    logic [AW-1:0]   m_axi_awaddr, m_axi_araddr;
    logic [7:0]      m_axi_awlen, m_axi_arlen;
    logic [2:0]      m_axi_awsize, m_axi_arsize;
    logic [1:0]      m_axi_awburst, m_axi_arburst;
    logic            m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, m_axi_arvalid, m_axi_rready;
    logic [DW-1:0]   m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic            m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_arready = 1'b0;
    logic [1:0]      m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;
    logic            m_axi_bvalid = 1'b0, m_axi_rvalid = 1'b0, m_axi_rlast = 1'b0;
    logic [DW-1:0]   m_axi_rdata = '0;

    always #5 mig_clk = ~mig_clk;

    axi_mem_tester #(.DW(DW), .AW(AW), .BURST_BEATS(BB)) dut (
        .mig_clk(mig_clk), .mig_rst(mig_rst), .init_calib_complete(init_calib_complete),
        .start(start), .seed(seed), .base_addr(base_addr), .num_bursts(num_bursts),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    typedef struct {
        logic [31:0] seed;
        logic [31:0] base;
        int          nb;
        int          stall;
        int          slverr_burst;
        int          flip_burst;
        int          flip_beat;
        int          drop_rlast_burst;
        int          exp_pass;
        int          exp_err;
        logic [31:0] exp_first;
        int          exp_aw;
        int          exp_w;
        int          exp_ar;
        logic [31:0] exp_word0;
    } vec_t;

    vec_t vecs[7];

    // Run configuration, written only by the main sequence.
    int          run_id = 0;
    int          stall_en = 0;
    int          slverr_burst = -1, flip_burst = -1, flip_beat = 0, drop_rlast_burst = -1;
    logic [31:0] base_eff = '0;

    // Observations, written only by the responder.
    int             aw_count = 0, w_count = 0, ar_count = 0;
    int             proto_err = 0, stab_viol = 0, valid_cnt = 0;
    logic [DW-1:0]  first_wdata = '0;
    logic [AW-1:0]  first_awaddr = '0;
    logic [DW-1:0]  mem [0:255];

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic int rwait();
        return (stall_en != 0) ? int'($urandom_range(7, 0)) : 0;
    endfunction

    initial begin : responder
        logic          aw_hs, w_hs, b_hs, ar_hs, r_hs, s_wlast, hold_wlast;
        logic [AW-1:0] s_awaddr, s_araddr, hold_awaddr, hold_araddr, w_addr, r_addr;
        logic [7:0]    s_awlen, s_arlen;
        logic [2:0]    s_awsize, s_arsize;
        logic [1:0]    s_awburst, s_arburst;
        logic [DW-1:0] s_wdata, hold_wdata;
        logic [DW/8-1:0] s_wstrb;
        int  seen_run, aw_wait, w_wait, ar_wait, b_wait, r_wait, w_beat, r_beat, b_idx, rd_burst;
        bit  aw_hold, w_hold, ar_hold, b_pend, r_active;
        seen_run = 0; aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        w_beat = 0; r_beat = 0; b_idx = 0; rd_burst = 0;
        aw_hold = 0; w_hold = 0; ar_hold = 0; b_pend = 0; r_active = 0;
        w_addr = '0; r_addr = '0; hold_awaddr = '0; hold_araddr = '0; hold_wdata = '0; hold_wlast = 0;
        forever begin
            @(negedge mig_clk);
            if (run_id != seen_run) begin
                seen_run = run_id;
                aw_count = 0; w_count = 0; ar_count = 0; b_idx = 0;
                first_wdata = '0; first_awaddr = '0;
            end
            aw_hs = m_axi_awvalid && m_axi_awready;
            w_hs  = m_axi_wvalid && m_axi_wready;
            b_hs  = m_axi_bvalid && m_axi_bready;
            ar_hs = m_axi_arvalid && m_axi_arready;
            r_hs  = m_axi_rvalid && m_axi_rready;
            s_awaddr = m_axi_awaddr; s_awlen = m_axi_awlen; s_awsize = m_axi_awsize; s_awburst = m_axi_awburst;
            s_araddr = m_axi_araddr; s_arlen = m_axi_arlen; s_arsize = m_axi_arsize; s_arburst = m_axi_arburst;
            s_wdata = m_axi_wdata; s_wstrb = m_axi_wstrb; s_wlast = m_axi_wlast;
            if (m_axi_awvalid || m_axi_wvalid || m_axi_arvalid) valid_cnt++;
            if (!mig_rst) begin
                if (aw_hold && (!m_axi_awvalid || m_axi_awaddr != hold_awaddr)) stab_viol++;
                if (w_hold && (!m_axi_wvalid || m_axi_wdata != hold_wdata || m_axi_wlast != hold_wlast)) stab_viol++;
                if (ar_hold && (!m_axi_arvalid || m_axi_araddr != hold_araddr)) stab_viol++;
            end
            aw_hold = m_axi_awvalid && !m_axi_awready; hold_awaddr = m_axi_awaddr;
            w_hold  = m_axi_wvalid && !m_axi_wready;   hold_wdata = m_axi_wdata; hold_wlast = m_axi_wlast;
            ar_hold = m_axi_arvalid && !m_axi_arready; hold_araddr = m_axi_araddr;

            @(posedge mig_clk);
            #1;
            if (mig_rst) begin
                m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
                m_axi_bvalid = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
                aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
                b_pend = 0; r_active = 0; aw_hold = 0; w_hold = 0; ar_hold = 0;
            end else begin
                if (aw_hs) begin
                    if (aw_count == 0) first_awaddr = s_awaddr;
                    if (s_awaddr != base_eff + 32'(aw_count * BB * 16) || s_awlen != 8'(BB - 1) ||
                        s_awsize != 3'b100 || s_awburst != 2'b01) proto_err++;
                    aw_count++;
                    w_addr = s_awaddr; w_beat = 0;
                    aw_wait = rwait(); m_axi_awready = (aw_wait == 0);
                end else if (!m_axi_awready) begin
                    if (aw_wait == 0) m_axi_awready = 1'b1; else aw_wait--;
                end

                if (w_hs) begin
                    if (w_count == 0) first_wdata = s_wdata;
                    if (s_wlast != (w_beat == BB - 1) || s_wstrb != '1) proto_err++;
                    mem[w_addr[11:4]] = s_wdata;
                    w_count++; w_beat++; w_addr = w_addr + 32'd16;
                    if (w_beat == BB) begin b_pend = 1; b_wait = rwait(); end
                    w_wait = rwait(); m_axi_wready = (w_wait == 0);
                end else if (!m_axi_wready) begin
                    if (w_wait == 0) m_axi_wready = 1'b1; else w_wait--;
                end

                if (b_hs) begin m_axi_bvalid = 0; b_idx++; end
                if (b_pend && !m_axi_bvalid) begin
                    if (b_wait == 0) begin
                        m_axi_bvalid = 1;
                        m_axi_bresp  = (b_idx == slverr_burst) ? 2'b10 : 2'b00;
                        b_pend = 0;
                    end else b_wait--;
                end

                if (ar_hs) begin
                    if (s_araddr != base_eff + 32'(ar_count * BB * 16) || s_arlen != 8'(BB - 1) ||
                        s_arsize != 3'b100 || s_arburst != 2'b01) proto_err++;
                    rd_burst = ar_count; ar_count++;
                    r_addr = s_araddr; r_beat = 0; r_active = 1; r_wait = rwait();
                    ar_wait = rwait(); m_axi_arready = (ar_wait == 0);
                end else if (!m_axi_arready) begin
                    if (ar_wait == 0) m_axi_arready = 1'b1; else ar_wait--;
                end

                if (r_hs) begin
                    r_beat++; r_addr = r_addr + 32'd16; m_axi_rvalid = 0; r_wait = rwait();
                    if (r_beat == BB) r_active = 0;
                end
                if (r_active && !m_axi_rvalid) begin
                    if (r_wait == 0) begin
                        m_axi_rdata = mem[r_addr[11:4]];
                        if (rd_burst == flip_burst && r_beat == flip_beat) m_axi_rdata[0] = ~m_axi_rdata[0];
                        m_axi_rlast  = (r_beat == BB - 1) && (rd_burst != drop_rlast_burst);
                        m_axi_rresp  = 2'b00;
                        m_axi_rvalid = 1;
                    end else r_wait--;
                end
            end
        end
    end

    task automatic setup_cfg(input vec_t v);
        stall_en = v.stall; slverr_burst = v.slverr_burst;
        flip_burst = v.flip_burst; flip_beat = v.flip_beat; drop_rlast_burst = v.drop_rlast_burst;
        base_eff = v.base & 32'hFFFF_FF00;
        run_id++;
    endtask

    task automatic pulse_start(input logic [31:0] s, input logic [31:0] b, input int n);
        @(posedge mig_clk); #1;
        seed = s; base_addr = b; num_bursts = 16'(n); start = 1'b1;
        @(posedge mig_clk); #1;
        start = 1'b0;
    endtask

    task automatic run_vec(input int i);
        int cyc;
        vec_t v;
        string tag;
        v = vecs[i];
        tag = $sformatf("v%0d", i);
        setup_cfg(v);
        pulse_start(v.seed, v.base, v.nb);
        cyc = 0;
        while (done !== 1'b1 && cyc < 20000) begin
            @(negedge mig_clk);
            cyc++;
        end
        @(negedge mig_clk);
        check({tag, "_done"}, done, 1);
        check({tag, "_pass"}, pass, 128'(v.exp_pass));
        check({tag, "_err_count"}, err_count, 128'(v.exp_err));
        check({tag, "_first_err_addr"}, first_err_addr, v.exp_first);
        check({tag, "_aw_bursts"}, aw_count, v.exp_aw);
        check({tag, "_w_beats"}, w_count, v.exp_w);
        check({tag, "_ar_bursts"}, ar_count, v.exp_ar);
        check({tag, "_awaddr0"}, first_awaddr, v.base & 32'hFFFF_FF00);
        check({tag, "_wdata0"}, first_wdata, {4{v.exp_word0}});
    endtask

    initial begin : main
        int cyc;
        int vc0;
        bit busy_seen;
        //             seed          base        nb st slv flb fbt drl pass err first         aw  w   ar  word0
        vecs[0] = '{32'h0000_0000, 32'h1000, 2, 0, -1, -1, 0, -1, 1, 0, 32'h0000_0000, 2, 32, 2, 32'h0000_1000};
        vecs[1] = '{32'h0000_0000, 32'h1000, 2, 0, -1,  1, 5, -1, 0, 1, 32'h0000_1150, 2, 32, 2, 32'h0000_1000};
        vecs[2] = '{32'h0000_0000, 32'h1000, 2, 1, -1, -1, 0, -1, 1, 0, 32'h0000_0000, 2, 32, 2, 32'h0000_1000};
        vecs[3] = '{32'h0000_0000, 32'h1000, 2, 0,  0, -1, 0, -1, 0, 1, 32'h0000_1000, 2, 32, 2, 32'h0000_1000};
        vecs[4] = '{32'hA5A5_0000, 32'h10FF, 1, 1, -1, -1, 0, -1, 1, 0, 32'h0000_0000, 1, 16, 1, 32'hA5A5_1000};
        vecs[5] = '{32'h1234_5678, 32'h1000, 2, 1,  0,  1, 3, -1, 0, 2, 32'h0000_1000, 2, 32, 2, 32'h1234_4678};
        vecs[6] = '{32'h0000_0000, 32'h1200, 1, 0, -1, -1, 0,  0, 0, 1, 32'h0000_12F0, 1, 16, 1, 32'h0000_1200};

        #2 mig_rst = 1'b1;
        repeat (2) @(negedge mig_clk);
        check("rst_err_count", err_count, 0);
        check("rst_first_err_addr", first_err_addr, 0);
        check("rst_ctrl", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, busy, done, pass}, 0);
        @(posedge mig_clk); #1 mig_rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(i);

        // Zero-burst run: finishes almost at once and never touches the bus.
        setup_cfg(vecs[0]);
        vc0 = valid_cnt;
        pulse_start(32'h0, 32'h1000, 0);
        cyc = 0;
        while (done !== 1'b1 && cyc < 2) begin
            @(negedge mig_clk);
            cyc++;
        end
        check("nb0_done", done, 1);
        check("nb0_pass", pass, 1);
        check("nb0_err_cleared", err_count, 0);
        repeat (4) @(negedge mig_clk);
        check("nb0_no_valid", valid_cnt - vc0, 0);

        // Start while calibration is incomplete is ignored.
        init_calib_complete = 1'b0;
        pulse_start(32'h0, 32'h1000, 2);
        busy_seen = 0;
        repeat (4) begin
            @(negedge mig_clk);
            if (busy) busy_seen = 1;
        end
        check("nocalib_busy", busy_seen, 0);
        init_calib_complete = 1'b1;

        // Reset in the middle of the write data phase.
        setup_cfg(vecs[0]);
        pulse_start(32'h0, 32'h1000, 2);
        cyc = 0;
        while (m_axi_wvalid !== 1'b1 && cyc < 200) begin
            @(negedge mig_clk);
            cyc++;
        end
        check("midrst_wr_data_reached", m_axi_wvalid, 1);
        #2 mig_rst = 1'b1;
        #1;
        check("midrst_async_wvalid", m_axi_wvalid, 0);
        @(negedge mig_clk);
        check("midrst_idle", {busy, done, pass, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 0);
        check("midrst_err_count", err_count, 0);
        @(posedge mig_clk); #1 mig_rst = 1'b0;

        run_vec(0);

        check("payload_stable", stab_viol, 0);
        check("protocol", proto_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
